// File: rtl/oddr_pkg.sv
// Shared types and helpers for the ODDR serializer: FSM state and beat arithmetic.
package oddr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // One bit pair leaves per clock, so a word occupies WIDTH/2 cycles.
  function automatic int beats_f(input int width);
    return width / 2;
  endfunction

  function automatic int cnt_width_f(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/oddr_serializer_if.sv
// Parallel-word valid/ready stream feeding the ODDR serializer.
interface oddr_serializer_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );

endinterface

// File: rtl/oddr_serializer.sv
// Splits parallel words into (d1, d2) bit pairs for a same-clock DDR output register.
// Define ODDR_SER_TRAINING_EN to idle with d1=1/d2=0 (forwarded-clock training) instead of IDLE_VAL.
module oddr_serializer
  import oddr_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter logic IDLE_VAL  = 1'b0,
  parameter bit   MSB_FIRST = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  oddr_serializer_if.slave    s,
  output logic                d1,
  output logic                d2,
  output logic                busy,
  output logic                underrun
);

  localparam int              BEATS     = beats_f(WIDTH);
  localparam int              CNT_W     = cnt_width_f(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

`ifdef ODDR_SER_TRAINING_EN
  localparam logic IDLE_D1 = 1'b1;
  localparam logic IDLE_D2 = 1'b0;
`else
  localparam logic IDLE_D1 = IDLE_VAL;
  localparam logic IDLE_D2 = IDLE_VAL;
`endif

  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("oddr_serializer: WIDTH must be even and >= 2");
    end
  endgenerate

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] sreg_reg;
  logic             d1_reg;
  logic             d2_reg;
  logic             busy_reg;
  logic             underrun_reg;

  logic last_beat;
  logic xfer;

  // Next pair to leave the word, in the configured bit order.
  function automatic logic [1:0] head_pair(input logic [WIDTH-1:0] w);
    if (MSB_FIRST)
      return {w[WIDTH-1], w[WIDTH-2]};
    else
      return {w[0], w[1]};
  endfunction

  function automatic logic [WIDTH-1:0] drop_pair(input logic [WIDTH-1:0] w);
    if (MSB_FIRST)
      return w << 2;
    else
      return w >> 2;
  endfunction

  assign last_beat = (state_reg == SHIFT) && (cnt_reg == LAST_BEAT);
  assign s.s_ready = rst && ((state_reg == IDLE) || last_beat);
  assign xfer      = s.s_valid && s.s_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      sreg_reg     <= '0;
      d1_reg       <= IDLE_D1;
      d2_reg       <= IDLE_D2;
      busy_reg     <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      underrun_reg <= 1'b0;
      if (xfer) begin
        // Taking a word on the last beat chains it directly after the previous one.
        state_reg        <= SHIFT;
        busy_reg         <= 1'b1;
        cnt_reg          <= '0;
        {d1_reg, d2_reg} <= head_pair(s.s_data);
        sreg_reg         <= drop_pair(s.s_data);
      end else if (state_reg == SHIFT) begin
        if (last_beat) begin
          state_reg    <= IDLE;
          busy_reg     <= 1'b0;
          cnt_reg      <= '0;
          sreg_reg     <= '0;
          d1_reg       <= IDLE_D1;
          d2_reg       <= IDLE_D2;
          underrun_reg <= 1'b1;
        end else begin
          cnt_reg          <= cnt_reg + CNT_W'(1);
          {d1_reg, d2_reg} <= head_pair(sreg_reg);
          sreg_reg         <= drop_pair(sreg_reg);
        end
      end
    end
  end

  assign d1       = d1_reg;
  assign d2       = d2_reg;
  assign busy     = busy_reg;
  assign underrun = underrun_reg;

endmodule

// File: tb/tb_oddr_serializer.sv
// Bench for oddr_serializer: three instances (8-bit LSB-first, 8-bit MSB-first idle-high, 2-bit) against a pair-list model.
module tb_oddr_serializer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       vld [3];
  logic [7:0] dat [3];
  logic       o_d1 [3];
  logic       o_d2 [3];
  logic       o_busy [3];
  logic       o_und [3];
  logic       rdy [3];

  int checks = 0;
  int errors = 0;

  oddr_serializer_if #(.WIDTH(8)) if0 ();
  oddr_serializer_if #(.WIDTH(8)) if1 ();
  oddr_serializer_if #(.WIDTH(2)) if2 ();

  assign if0.s_valid = vld[0];
  assign if0.s_data  = dat[0];
  assign if1.s_valid = vld[1];
  assign if1.s_data  = dat[1];
  assign if2.s_valid = vld[2];
  assign if2.s_data  = dat[2][1:0];
  assign rdy[0] = if0.s_ready;
  assign rdy[1] = if1.s_ready;
  assign rdy[2] = if2.s_ready;

  oddr_serializer #(.WIDTH(8), .IDLE_VAL(1'b0), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst_n), .s(if0.slave),
    .d1(o_d1[0]), .d2(o_d2[0]), .busy(o_busy[0]), .underrun(o_und[0])
  );
  oddr_serializer #(.WIDTH(8), .IDLE_VAL(1'b1), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst_n), .s(if1.slave),
    .d1(o_d1[1]), .d2(o_d2[1]), .busy(o_busy[1]), .underrun(o_und[1])
  );
  oddr_serializer #(.WIDTH(2), .IDLE_VAL(1'b0), .MSB_FIRST(1'b0)) dut2 (
    .clk(clk), .rst(rst_n), .s(if2.slave),
    .d1(o_d1[2]), .d2(o_d2[2]), .busy(o_busy[2]), .underrun(o_und[2])
  );

  function automatic int wid(input int k);
    return (k == 2) ? 2 : 8;
  endfunction

  function automatic logic [1:0] idle_pat(input int k);
`ifdef ODDR_SER_TRAINING_EN
    return 2'b10;
`else
    return (k == 1) ? 2'b11 : 2'b00;
`endif
  endfunction

  // Pair j of word w as {d1, d2}, straight from the bit-numbering rule.
  function automatic logic [1:0] pair_of(input int k, input logic [7:0] w, input int j);
    int n;
    n = wid(k);
    if (k == 1)
      return {w[n-1-2*j], w[n-2-2*j]};
    return {w[2*j], w[2*j+1]};
  endfunction

  // Model: current word, index of the pair on the pins, and whether a word is in flight.
  logic       m_busy [3];
  int         m_idx  [3];
  logic [1:0] m_cur  [3];
  logic       m_und  [3];
  logic [7:0] m_word [3];

  function automatic logic exp_ready(input int k);
    return rst_n && (!m_busy[k] || (m_idx[k] == wid(k)/2 - 1));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_busy[k] <= 1'b0;
        m_idx[k]  <= 0;
        m_cur[k]  <= idle_pat(k);
        m_und[k]  <= 1'b0;
        m_word[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_und[k] <= 1'b0;
        if (vld[k] && exp_ready(k)) begin
          m_word[k] <= dat[k];
          m_idx[k]  <= 0;
          m_cur[k]  <= pair_of(k, dat[k], 0);
          m_busy[k] <= 1'b1;
        end else if (m_busy[k] && (m_idx[k] < wid(k)/2 - 1)) begin
          m_idx[k] <= m_idx[k] + 1;
          m_cur[k] <= pair_of(k, m_word[k], m_idx[k] + 1);
        end else if (m_busy[k]) begin
          m_busy[k] <= 1'b0;
          m_cur[k]  <= idle_pat(k);
          m_und[k]  <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h want %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk("model_pair", k, {6'b0, o_d1[k], o_d2[k]}, {6'b0, m_cur[k]});
      chk("model_busy", k, {7'b0, o_busy[k]}, {7'b0, m_busy[k]});
      chk("model_underrun", k, {7'b0, o_und[k]}, {7'b0, m_und[k]});
      chk("model_ready", k, {7'b0, rdy[k]}, {7'b0, exp_ready(k)});
    end
  end

  logic [1:0] b4_lsb [4];
  logic [1:0] b4_msb [4];
  logic [1:0] w2_dat [3];
  logic [1:0] w2_exp [3];

  initial begin
    b4_lsb = '{2'b00, 2'b10, 2'b11, 2'b01};
    b4_msb = '{2'b10, 2'b11, 2'b01, 2'b00};
    w2_dat = '{2'b01, 2'b10, 2'b11};
    w2_exp = '{2'b10, 2'b01, 2'b11};
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vld[k] = 1'b0;
      dat[k] = '0;
    end

    repeat (3) @(negedge clk);
    chk("rst_ready", 0, {7'b0, rdy[0]}, 8'd0);
    chk("rst_busy", 0, {7'b0, o_busy[0]}, 8'd0);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
`ifdef ODDR_SER_TRAINING_EN
    chk("idle_pattern", 1, {6'b0, o_d1[1], o_d2[1]}, 8'h02);
`else
    chk("idle_pattern", 1, {6'b0, o_d1[1], o_d2[1]}, 8'h03);
`endif

    // Single word 8'hB4 on both 8-bit instances.
    #1 vld[0] = 1'b1; vld[1] = 1'b1; dat[0] = 8'hB4; dat[1] = 8'hB4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b4_lsb_pair", 0, {6'b0, o_d1[0], o_d2[0]}, {6'b0, b4_lsb[i]});
      chk("b4_msb_pair", 1, {6'b0, o_d1[1], o_d2[1]}, {6'b0, b4_msb[i]});
      chk("b4_busy", 0, {7'b0, o_busy[0]}, 8'd1);
      if (i == 0) begin
        #1 vld[0] = 1'b0; vld[1] = 1'b0;
      end
    end
    @(negedge clk);
    chk("b4_underrun", 0, {7'b0, o_und[0]}, 8'd1);
    chk("b4_underrun", 1, {7'b0, o_und[1]}, 8'd1);
    chk("b4_busy_end", 0, {7'b0, o_busy[0]}, 8'd0);
    @(negedge clk);
    chk("b4_underrun_once", 0, {7'b0, o_und[0]}, 8'd0);

    // Back-to-back 8'hFF then 8'h00 with s_valid held.
    #1 vld[0] = 1'b1; dat[0] = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("b2b_pair", 0, {6'b0, o_d1[0], o_d2[0]}, (i < 4) ? 8'h03 : 8'h00);
      chk("b2b_ready", 0, {7'b0, rdy[0]}, (i == 3 || i == 7) ? 8'd1 : 8'd0);
      chk("b2b_underrun", 0, {7'b0, o_und[0]}, 8'd0);
      if (i == 0) begin
        #1 dat[0] = 8'h00;
      end
      if (i == 4) begin
        #1 vld[0] = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_underrun_end", 0, {7'b0, o_und[0]}, 8'd1);

    // Reset during beat 2 of 8'hAA.
    #1 vld[0] = 1'b1; dat[0] = 8'hAA;
    @(negedge clk);
    #1 vld[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_pair", 0, {6'b0, o_d1[0], o_d2[0]}, {6'b0, idle_pat(0)});
    chk("midrst_busy", 0, {7'b0, o_busy[0]}, 8'd0);
    chk("midrst_ready", 0, {7'b0, rdy[0]}, 8'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("postrst_idle", 0, {6'b0, o_d1[0], o_d2[0]}, {6'b0, idle_pat(0)});
    end

    // Word presented together with reset release is taken on the first edge.
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1; vld[0] = 1'b1; dat[0] = 8'h5D;
    @(negedge clk);
    chk("first_edge_pair", 0, {6'b0, o_d1[0], o_d2[0]}, 8'h02);
    chk("first_edge_busy", 0, {7'b0, o_busy[0]}, 8'd1);
    #1 vld[0] = 1'b0;
    repeat (5) @(negedge clk);

    // WIDTH=2 stream with s_valid held.
    #1 vld[2] = 1'b1; dat[2] = {6'b0, w2_dat[0]};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("w2_pair", 2, {6'b0, o_d1[2], o_d2[2]}, {6'b0, w2_exp[i]});
      chk("w2_ready", 2, {7'b0, rdy[2]}, 8'd1);
      #1;
      if (i < 2) dat[2] = {6'b0, w2_dat[i+1]};
      else vld[2] = 1'b0;
    end
    @(negedge clk);
    chk("w2_underrun", 2, {7'b0, o_und[2]}, 8'd1);
    chk("w2_ready_end", 2, {7'b0, rdy[2]}, 8'd1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oddr_serializer.md
ODDR_SERIALIZER -- requirements
Module: oddr_serializer

Interface
REQ-001 Param WIDTH, default 8, parallel word width; even, >= 2.
REQ-002 Param IDLE_VAL, default 1'b0, value driven on d1/d2 when no word is in flight.
REQ-003 Param MSB_FIRST, default 0; 0 = bit 0 leaves first, 1 = bit WIDTH-1 leaves first.
REQ-004 clk  input  1  single clock; d1/d2 feed a downstream DDR output register on the same clk.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 s_data  input  WIDTH  parallel word to serialize.
REQ-007 s_valid  input  1  s_data valid.
REQ-008 s_ready  output  1  block accepts s_data this cycle.
REQ-009 d1  output  1  bit for rising-edge half of the DDR cycle.
REQ-010 d2  output  1  bit for falling-edge half of the DDR cycle.
REQ-011 busy  output  1  high while a word is being shifted out.
REQ-012 underrun  output  1  one-cycle pulse when the stream stops for lack of a next word.

Function
REQ-013 Transfer occurs on a rising clk edge when s_valid && s_ready; s_data is not sampled otherwise.
REQ-014 Two states: IDLE and SHIFT; BEATS = WIDTH/2 cycles per word; beat counter width $clog2(BEATS), minimum 1.
REQ-015 s_ready = 1 in IDLE; in SHIFT, 1 only on the last beat (counter == BEATS-1); 0 while rst is low.
REQ-016 On transfer: state <= SHIFT, counter <= 0, d1/d2 (registered) <= first bit pair, remaining bits loaded into shift register.
REQ-017 First pair (MSB_FIRST=0): d1 = s_data[0], d2 = s_data[1]; pair k: d1 = bit 2k, d2 = bit 2k+1; MSB_FIRST=1 mirrors (d1 = bit WIDTH-1-2k, d2 = bit WIDTH-2-2k).
REQ-018 Latency: first pair visible on d1/d2 immediately after the accepting edge; each later pair one cycle after the previous one.
REQ-019 Back-to-back: transfer on the last beat loads the new word with no gap or idle pair between words.
REQ-020 Last beat without transfer: state <= IDLE, d1/d2 <= idle pattern, underrun pulses high for exactly the next cycle.
REQ-021 underrun never asserts on the IDLE -> SHIFT transition or while remaining in IDLE.
REQ-022 busy = (state == SHIFT), registered.
REQ-023 WIDTH = 2: every SHIFT cycle is the last beat; s_ready stays 1 continuously.
REQ-024 s_valid deasserted or s_data changed while not ready has no effect.

Reset
REQ-025 rst low: state IDLE, counter 0, shift register 0, d1 = d2 = idle pattern, busy 0, underrun 0, s_ready 0, asynchronously.
REQ-026 Reset mid-word aborts the word; no remaining bits are emitted after release.
REQ-027 First transfer is possible on the first rising edge after rst deasserts.

Configuration
REQ-028 Macro ODDR_SER_TRAINING_EN: defined -> idle pattern is d1 = 1, d2 = 0 (forwarded-clock training pattern), IDLE_VAL ignored.
REQ-029 Not defined -> idle pattern is d1 = d2 = IDLE_VAL; all other behaviour identical.

Structure
REQ-030 Shared package oddr_pkg holds the state enum (IDLE, SHIFT) and a beats_f(WIDTH) function returning WIDTH/2.
REQ-031 No sub-module; single flat module, all state registered on clk.
REQ-032 Elaboration check rejects odd WIDTH or WIDTH < 2.

Verification
REQ-033 WIDTH=8, MSB_FIRST=0, single word 8'hB4 -> (d1,d2) pairs (0,0),(1,0),(1,1),(0,1); busy 4 cycles; underrun pulse next cycle.
REQ-034 Words 8'hFF then 8'h00 with s_valid held high -> 4 pairs (1,1) then 4 pairs (0,0), no gap; s_ready high only on beats 3 and 7.
REQ-035 MSB_FIRST=1, word 8'hB4 -> pairs (1,0),(1,1),(0,1),(0,0).
REQ-036 rst low during beat 2 of 8'hAA -> d1/d2 idle pattern immediately, busy 0, no further data bits after release.
REQ-037 With ODDR_SER_TRAINING_EN, no input -> d1=1, d2=0 every cycle; without it and IDLE_VAL=1 -> d1=d2=1.
REQ-038 WIDTH=2, s_valid held high, data 2'b01,2'b10,2'b11 -> pairs (1,0),(0,1),(1,1) on consecutive cycles; s_ready constant 1.
